// File: rtl/mem_xfer_engine_pkg.sv
// Shared definitions for the block-transfer sequencer. The CPU imports these
// encodings when it builds transfer requests.
package mem_xfer_engine_pkg;

  localparam int unsigned XFER_MODE_W = 2;

  typedef enum logic [XFER_MODE_W-1:0] {
    XFER_COPY_UP   = 2'd0,
    XFER_COPY_DOWN = 2'd1,
    XFER_FILL      = 2'd2,
    XFER_RSVD      = 2'd3
  } xfer_mode_e;

  typedef enum logic [2:0] {
    XFER_S_IDLE  = 3'd0,
    XFER_S_READ  = 3'd1,
    XFER_S_WRITE = 3'd2,
    XFER_S_FILL  = 3'd3,
    XFER_S_DONE  = 3'd4
  } xfer_state_e;

endpackage

// File: rtl/mem_xfer_engine.sv
// Block-transfer sequencer for the byte memory: ascending copy, descending copy
// (memmove-safe for overlapping dst>src) and fill, over the mem read/ack and write ports.
module mem_xfer_engine
  import mem_xfer_engine_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [XFER_MODE_W-1:0] mode,
  input  logic [ADDR_W-1:0]      src,
  input  logic [ADDR_W-1:0]      dst,
  input  logic [CNT_W-1:0]       count,
  input  logic [DATA_W-1:0]      fill_byte,
  output logic                   busy,
  output logic                   done,
  output logic                   mem_read,
  output logic [ADDR_W-1:0]      mem_read_idx,
  input  logic [DATA_W-1:0]      mem_read_byte,
  input  logic                   mem_read_ack,
  output logic                   mem_write,
  output logic [ADDR_W-1:0]      mem_write_idx,
  output logic [DATA_W-1:0]      mem_write_byte
);

  xfer_state_e       state_q, state_d;
  logic              down_q, down_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [ADDR_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [DATA_W-1:0] byte_q, byte_d;
  logic [DATA_W-1:0] fill_q, fill_d;

  xfer_mode_e        req_mode;
  logic [ADDR_W-1:0] cnt_ext;
  logic [ADDR_W-1:0] step;
  logic              last;

  assign req_mode = xfer_mode_e'(mode);
  assign cnt_ext  = ADDR_W'(count);
  // One adder for both directions: all-ones is -1 modulo 2**ADDR_W.
  assign step     = down_q ? '1 : ADDR_W'(1);
  assign last     = (remaining_q == CNT_W'(1));

  always_comb begin
    state_d        = state_q;
    down_d         = down_q;
    rd_d           = rd_q;
    wr_d           = wr_q;
    remaining_d    = remaining_q;
    byte_d         = byte_q;
    fill_d         = fill_q;
    busy           = (state_q != XFER_S_IDLE);
    done           = 1'b0;
    mem_read       = 1'b0;
    mem_read_idx   = '0;
    mem_write      = 1'b0;
    mem_write_idx  = '0;
    mem_write_byte = '0;

    unique case (state_q)
      XFER_S_IDLE: begin
        if (start) begin
          down_d      = (req_mode == XFER_COPY_DOWN);
          remaining_d = count;
          fill_d      = fill_byte;
          if (req_mode == XFER_COPY_DOWN) begin
            rd_d = src + cnt_ext - ADDR_W'(1);
            wr_d = dst + cnt_ext - ADDR_W'(1);
          end else begin
            rd_d = src;
            wr_d = dst;
          end
          if (count == '0 || req_mode == XFER_RSVD) state_d = XFER_S_DONE;
          else if (req_mode == XFER_FILL)           state_d = XFER_S_FILL;
          else                                      state_d = XFER_S_READ;
        end
      end
      XFER_S_READ: begin
        mem_read     = !mem_read_ack;
        mem_read_idx = rd_q;
        if (mem_read_ack) begin
          byte_d  = mem_read_byte;
          state_d = XFER_S_WRITE;
        end
      end
      XFER_S_WRITE: begin
        mem_write      = 1'b1;
        mem_write_idx  = wr_q;
        mem_write_byte = byte_q;
        remaining_d    = remaining_q - CNT_W'(1);
        rd_d           = rd_q + step;
        wr_d           = wr_q + step;
        state_d        = last ? XFER_S_DONE : XFER_S_READ;
      end
      XFER_S_FILL: begin
        mem_write      = 1'b1;
        mem_write_idx  = wr_q;
        mem_write_byte = fill_q;
        remaining_d    = remaining_q - CNT_W'(1);
        wr_d           = wr_q + ADDR_W'(1);
        state_d        = last ? XFER_S_DONE : XFER_S_FILL;
      end
      XFER_S_DONE: begin
        done    = 1'b1;
        state_d = XFER_S_IDLE;
      end
      default: state_d = XFER_S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= XFER_S_IDLE;
      down_q      <= 1'b0;
      rd_q        <= '0;
      wr_q        <= '0;
      remaining_q <= '0;
      byte_q      <= '0;
      fill_q      <= '0;
    end else begin
      state_q     <= state_d;
      down_q      <= down_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      remaining_q <= remaining_d;
      byte_q      <= byte_d;
      fill_q      <= fill_d;
    end
  end

endmodule

// File: tb/tb_mem_xfer_engine.sv
// Self-checking bench for mem_xfer_engine: memory model with 1-cycle read ack,
// expected-write scoreboard, table of transfers plus reset and mid-copy start sequences.
module tb_mem_xfer_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  mode;
  logic [11:0] src, dst;
  logic [8:0]  count;
  logic [7:0]  fill_byte;
  logic        busy, done;
  logic        mem_read;
  logic [11:0] mem_read_idx;
  logic [7:0]  mem_read_byte;
  logic        mem_read_ack;
  logic        mem_write;
  logic [11:0] mem_write_idx;
  logic [7:0]  mem_write_byte;

  mem_xfer_engine #(.ADDR_W(12), .DATA_W(8), .CNT_W(9)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .src(src), .dst(dst),
    .count(count), .fill_byte(fill_byte), .busy(busy), .done(done),
    .mem_read(mem_read), .mem_read_idx(mem_read_idx), .mem_read_byte(mem_read_byte),
    .mem_read_ack(mem_read_ack), .mem_write(mem_write), .mem_write_idx(mem_write_idx),
    .mem_write_byte(mem_write_byte)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] idx;
    logic [7:0]  b;
  } wr_t;

  typedef struct {
    logic [1:0]  mode;
    logic [11:0] src;
    logic [11:0] dst;
    logic [8:0]  count;
    logic [7:0]  fb;
    int          exp_cyc;
    bit          mid_start;
  } vec_t;

  logic [7:0] mem [4096];
  wr_t        exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         done_cnt = 0;
  bit         fill_active = 0;
  bit         pend = 0;
  logic [11:0] pidx;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory responder and write monitor, sampling 2 time units after each edge.
  initial begin
    mem_read_ack  = 1'b0;
    mem_read_byte = '0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_read_ack) mem_read_ack = 1'b0;
      if (pend) begin
        mem_read_ack  = 1'b1;
        mem_read_byte = mem[pidx];
        pend          = 0;
      end else if (mem_read) begin
        pend = 1;
        pidx = mem_read_idx;
      end
      chk("rw_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
      if (fill_active) chk("no_read_in_fill", {31'd0, mem_read}, 32'd0);
      if (done) done_cnt++;
      if (mem_write) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {20'd0, mem_write_idx}, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("write_idx_byte", {12'd0, mem_write_idx, mem_write_byte}, {12'd0, e.idx, e.b});
        end
        mem[mem_write_idx] = mem_write_byte;
      end
    end
  end

  // Expected writes from a snapshot of memory; descending order for COPY_DOWN gives memmove semantics.
  task automatic push_expected(input vec_t v);
    logic [11:0] off, a_s, a_d;
    if (v.mode == 2'd3) return;
    for (int i = 0; i < int'(v.count); i++) begin
      off = (v.mode == 2'd1) ? 12'(int'(v.count) - 1 - i) : 12'(i);
      a_s = v.src + off;
      a_d = v.dst + off;
      if (v.mode == 2'd2) exp_q.push_back('{idx: a_d, b: v.fb});
      else                exp_q.push_back('{idx: a_d, b: mem[a_s]});
    end
  endtask

  task automatic run_xfer(input vec_t v, input string nm);
    int k;
    int d0;
    int limit;
    push_expected(v);
    fill_active = (v.mode == 2'd2);
    d0 = done_cnt;
    mode = v.mode; src = v.src; dst = v.dst; count = v.count; fill_byte = v.fb;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    limit = v.exp_cyc + 40;
    while (!done && k < limit) begin
      if (v.mid_start && k == 4) begin
        start = 1'b1; mode = 2'd2; dst = 12'h000; src = 12'h555; count = 9'd1; fill_byte = 8'hEE;
      end
      if (v.mid_start && k == 5) start = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    chk({nm, "_done_seen"}, {31'd0, done}, 32'd1);
    chk({nm, "_cycles"}, k, v.exp_cyc);
    chk({nm, "_busy_in_done"}, {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    chk({nm, "_busy_after"}, {31'd0, busy | done}, 32'd0);
    @(posedge clk); #1;
    chk({nm, "_done_pulses"}, done_cnt - d0, 1);
    chk({nm, "_writes_left"}, exp_q.size(), 0);
    exp_q.delete();
    fill_active = 0;
  endtask

  vec_t vecs[8];

  initial begin
    vec_t rv;
    int d0;
    vecs[0] = '{mode: 2'd2, src: 12'h000, dst: 12'h100, count: 9'd256, fb: 8'h00, exp_cyc: 256, mid_start: 0};
    vecs[1] = '{mode: 2'd0, src: 12'h020, dst: 12'h300, count: 9'd16,  fb: 8'h00, exp_cyc: 48,  mid_start: 0};
    vecs[2] = '{mode: 2'd1, src: 12'h100, dst: 12'h108, count: 9'hF8,  fb: 8'h00, exp_cyc: 744, mid_start: 0};
    vecs[3] = '{mode: 2'd2, src: 12'h000, dst: 12'hFFE, count: 9'd4,   fb: 8'hAA, exp_cyc: 4,   mid_start: 0};
    vecs[4] = '{mode: 2'd0, src: 12'h400, dst: 12'h500, count: 9'd0,   fb: 8'h00, exp_cyc: 0,   mid_start: 0};
    vecs[5] = '{mode: 2'd0, src: 12'h600, dst: 12'h700, count: 9'd8,   fb: 8'h00, exp_cyc: 24,  mid_start: 1};
    vecs[6] = '{mode: 2'd1, src: 12'hFFE, dst: 12'h040, count: 9'd4,   fb: 8'h00, exp_cyc: 12,  mid_start: 0};
    vecs[7] = '{mode: 2'd3, src: 12'h000, dst: 12'h000, count: 9'd5,   fb: 8'h33, exp_cyc: 0,   mid_start: 0};

    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    reset = 1'b1; start = 1'b0; mode = '0; src = '0; dst = '0; count = '0; fill_byte = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {25'd0, busy, done, mem_read, mem_write, 3'd0},  32'd0);
    chk("reset_idx_byte", {mem_read_idx, mem_write_idx, mem_write_byte}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_xfer(vecs[i], $sformatf("vec%0d", i));

    // Reset while the first read of a 16-byte copy is outstanding.
    rv = '{mode: 2'd0, src: 12'h020, dst: 12'h800, count: 9'd16, fb: 8'h00, exp_cyc: 48, mid_start: 0};
    d0 = done_cnt;
    mode = rv.mode; src = rv.src; dst = rv.dst; count = rv.count;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("rst_mid_read_active", {31'd0, mem_read}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_outputs", {29'd0, busy, mem_read, mem_write}, 32'd0);
    reset = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("rst_mid_idle", {30'd0, busy, mem_write}, 32'd0);
    end
    chk("rst_mid_no_done", done_cnt - d0, 0);

    run_xfer('{mode: 2'd2, src: 12'h000, dst: 12'h7F0, count: 9'd8, fb: 8'h5A, exp_cyc: 8, mid_start: 0},
             "fill_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
